// File: rtl/mux_2_to_1.sv
// mux_2_to_1: enabled 2:1 selector with registered output.
// y carries a (se=1) or b (se=0) one cycle after sampling, or zero when disabled.
// y_vld is the registered copy of en.
module mux_2_to_1 #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             se,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             y_vld
);

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             y_vld_d;
  logic             y_vld_q;

  // Next-state select: only the chosen input reaches y_d, so the other one cannot disturb it.
  always_comb begin
    y_d     = '0;
    y_vld_d = 1'b0;
    if (en) begin
      y_vld_d = 1'b1;
      if (se) begin
        y_d = a;
      end else begin
        y_d = b;
      end
    end
  end

  // Output registers with synchronous reset, which takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= RESET_VAL;
      y_vld_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
    end
  end

  assign y     = y_q;
  assign y_vld = y_vld_q;

endmodule

// File: tb/tb_mux_2_to_1.sv
// Testbench for mux_2_to_1: directed vectors, expected results queued by the
// driver and checked by an independent monitor one cycle later.
module tb_mux_2_to_1;

  typedef struct {
    string      name;
    logic       y1;
    logic       v;
    logic [7:0] y8;
    logic [7:0] y8r;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       se;
  logic       en;
  logic       a1;
  logic       b1;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       y1;
  logic       v1;
  logic [7:0] y8;
  logic       v8;
  logic [7:0] y8r;
  logic       v8r;

  exp_t exp_q[$];
  int   total;
  int   bad;

  // Narrow instance, default reset value.
  mux_2_to_1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .se(se), .en(en), .y(y1), .y_vld(v1)
  );

  // Wide instance, default (zero) reset value.
  mux_2_to_1 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .se(se), .en(en), .y(y8), .y_vld(v8)
  );

  // Wide instance with a non-zero reset value.
  mux_2_to_1 #(.WIDTH(8), .RESET_VAL(8'hC3)) u_dut8r (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .se(se), .en(en), .y(y8r), .y_vld(v8r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "y1",    8'(y1),  8'(e.y1));
      check(e.name, "vld1",  8'(v1),  8'(e.v));
      check(e.name, "y8",    y8,      e.y8);
      check(e.name, "vld8",  8'(v8),  8'(e.v));
      check(e.name, "y8r",   y8r,     e.y8r);
      check(e.name, "vld8r", 8'(v8r), 8'(e.v));
    end
  end

  // Apply one vector and queue the response expected after the next rising edge.
  task automatic drive(input string name, input logic r, input logic e_n, input logic s,
                       input logic ia1, input logic ib1, input logic [7:0] ia8,
                       input logic [7:0] ib8, input logic ey1, input logic ev,
                       input logic [7:0] ey8, input logic [7:0] ey8r);
    exp_t e;
    @(negedge clk);
    rst = r; en = e_n; se = s;
    a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
    @(posedge clk);
    e.name = name; e.y1 = ey1; e.v = ev; e.y8 = ey8; e.y8r = ey8r;
    exp_q.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b1; se = 1'b1;
    a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;

    //    name        rst en se a1    b1    a8     b8     ey1 ev ey8    ey8r
    drive("reset0",   1,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 0,  0, 8'h00, 8'hC3);
    drive("reset1",   1,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 0,  0, 8'h00, 8'hC3);
    drive("rst_rel",  0,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1,  1, 8'hA5, 8'hA5);
    // select a
    drive("sel_a0",   0,  1, 1, 1'b1, 1'b0, 8'hFF, 8'h00, 1,  1, 8'hFF, 8'hFF);
    drive("sel_a1",   0,  1, 1, 1'b0, 1'b0, 8'h00, 8'h00, 0,  1, 8'h00, 8'h00);
    drive("sel_a2",   0,  1, 1, 1'b1, 1'b0, 8'h81, 8'h00, 1,  1, 8'h81, 8'h81);
    // select b
    drive("sel_b0",   0,  1, 0, 1'b1, 1'b0, 8'hA5, 8'h3C, 0,  1, 8'h3C, 8'h3C);
    drive("sel_b1",   0,  1, 0, 1'b0, 1'b1, 8'hA5, 8'h5A, 1,  1, 8'h5A, 8'h5A);
    // disable for 4 cycles, then re-enable
    for (int i = 0; i < 4; i++) begin
      drive("disable", 0, 0, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 0, 0, 8'h00, 8'h00);
    end
    drive("reenable", 0,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1,  1, 8'hA5, 8'hA5);
    // toggle se every cycle
    drive("tog0",     0,  1, 0, 1'b1, 1'b0, 8'hA5, 8'h3C, 0,  1, 8'h3C, 8'h3C);
    drive("tog1",     0,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1,  1, 8'hA5, 8'hA5);
    drive("tog2",     0,  1, 0, 1'b1, 1'b0, 8'hA5, 8'h3C, 0,  1, 8'h3C, 8'h3C);
    drive("tog3",     0,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1,  1, 8'hA5, 8'hA5);
    // unknown on the unselected input must not leak through
    drive("x_on_b",   0,  1, 1, 1'b1, 1'bx, 8'h5A, 8'hxx, 1,  1, 8'h5A, 8'h5A);
    drive("x_on_a",   0,  1, 0, 1'bx, 1'b0, 8'hxx, 8'h96, 0,  1, 8'h96, 8'h96);
    // disabled with unknown data still gives zero
    drive("x_dis",    0,  0, 1, 1'bx, 1'bx, 8'hxx, 8'hxx, 0,  0, 8'h00, 8'h00);
    // wide data, then reset mid-stream with en high
    drive("wide_a",   0,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1,  1, 8'hA5, 8'hA5);
    drive("wide_b",   0,  1, 0, 1'b1, 1'b0, 8'hA5, 8'h3C, 0,  1, 8'h3C, 8'h3C);
    drive("mid_rst",  1,  1, 1, 1'b1, 1'b0, 8'hA5, 8'h3C, 0,  0, 8'h00, 8'hC3);
    drive("resume",   0,  1, 0, 1'b0, 1'b1, 8'hA5, 8'h3C, 1,  1, 8'h3C, 8'h3C);
    drive("rst_dis",  1,  0, 0, 1'b0, 1'b1, 8'hA5, 8'h3C, 0,  0, 8'h00, 8'hC3);

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
